// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: control-bundle layouts, field positions and widths.
package mips_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    localparam int EX_W = 4;
    localparam int M_W  = 4;
    localparam int WB_W = 2;

    localparam int EX_REGDST   = 3;
    localparam int EX_ALUSRC   = 2;
    localparam int EX_ALUOP_HI = 1;
    localparam int EX_ALUOP_LO = 0;

    localparam int M_MEMREAD  = 3;
    localparam int M_MEMWRITE = 2;
    localparam int M_BRANCH   = 1;
    localparam int M_BOP      = 0;

    localparam int WB_REGWRITE = 1;
    localparam int WB_ALUSEL   = 0;

    typedef logic [EX_W-1:0] ex_ctrl_t;
    typedef logic [M_W-1:0]  m_ctrl_t;
    typedef logic [WB_W-1:0] wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t ex;
        m_ctrl_t  m;
        wb_ctrl_t wb;
    } ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE   = '0;
    localparam m_ctrl_t  M_BUBBLE    = '0;
    localparam wb_ctrl_t WB_BUBBLE   = '0;
    localparam ctrl_t    CTRL_BUBBLE = '{ex: EX_BUBBLE, m: M_BUBBLE, wb: WB_BUBBLE};

    // A load that actually writes a register is the only producer that can cause a load-use stall.
    function automatic logic is_reg_load(input m_ctrl_t m, input wb_ctrl_t wb);
        return m[M_MEMREAD] & wb[WB_REGWRITE];
    endfunction

endpackage

// File: rtl/id_ex_if.sv
// ID/EX pipeline bus: decode-stage values in, registered execute-stage values and stall out.
interface id_ex_if;
    import mips_pipe_pkg::*;

    ex_ctrl_t            id_EX_control;
    m_ctrl_t             id_M_control;
    wb_ctrl_t            id_WB_control;
    logic [DATA_W-1:0]   id_pc_plus4;
    logic [DATA_W-1:0]   id_rs_data;
    logic [DATA_W-1:0]   id_rt_data;
    logic [DATA_W-1:0]   id_imm;
    logic [REG_W-1:0]    id_rs;
    logic [REG_W-1:0]    id_rt;
    logic [REG_W-1:0]    id_rd;

    ex_ctrl_t            ex_EX_control;
    m_ctrl_t             ex_M_control;
    wb_ctrl_t            ex_WB_control;
    logic [DATA_W-1:0]   ex_pc_plus4;
    logic [DATA_W-1:0]   ex_rs_data;
    logic [DATA_W-1:0]   ex_rt_data;
    logic [DATA_W-1:0]   ex_imm;
    logic [REG_W-1:0]    ex_rs;
    logic [REG_W-1:0]    ex_rt;
    logic [REG_W-1:0]    ex_rd;

    logic                stall;

    modport master (
        output id_EX_control, id_M_control, id_WB_control,
        output id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
        input  ex_EX_control, ex_M_control, ex_WB_control,
        input  ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
        input  stall
    );

    modport slave (
        input  id_EX_control, id_M_control, id_WB_control,
        input  id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
        output ex_EX_control, ex_M_control, ex_WB_control,
        output ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
        output stall
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: the load in EX targets a source read by the instruction in ID.
module hazard_detect
    import mips_pipe_pkg::*;
(
    input  m_ctrl_t          ex_M_control,
    input  wb_ctrl_t         ex_WB_control,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hz
);

    // Both sources are compared regardless of opcode; a spurious stall is cheaper than decoding here.
    assign hz = is_reg_load(ex_M_control, ex_WB_control)
              & (ex_rt != '0)
              & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and saturating debug counters.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W = mips_pipe_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cnt_clr,
    id_ex_if.slave           bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic hz;
    logic stall;

    hazard_detect u_hazard_detect (
        .ex_M_control  (bus.ex_M_control),
        .ex_WB_control (bus.ex_WB_control),
        .ex_rt         (bus.ex_rt),
        .id_rs         (bus.id_rs),
        .id_rt         (bus.id_rt),
        .hz            (hz)
    );

    assign stall     = hz & ~flush;
    assign bus.stall = stall;

    // Data and addresses always follow ID; only the control bundle is squashed on bubble or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_EX_control <= EX_BUBBLE;
            bus.ex_M_control  <= M_BUBBLE;
            bus.ex_WB_control <= WB_BUBBLE;
            bus.ex_pc_plus4   <= '0;
            bus.ex_rs_data    <= '0;
            bus.ex_rt_data    <= '0;
            bus.ex_imm        <= '0;
            bus.ex_rs         <= '0;
            bus.ex_rt         <= '0;
            bus.ex_rd         <= '0;
        end else begin
            bus.ex_pc_plus4 <= bus.id_pc_plus4;
            bus.ex_rs_data  <= bus.id_rs_data;
            bus.ex_rt_data  <= bus.id_rt_data;
            bus.ex_imm      <= bus.id_imm;
            bus.ex_rs       <= bus.id_rs;
            bus.ex_rt       <= bus.id_rt;
            bus.ex_rd       <= bus.id_rd;
            if (flush || hz) begin
                bus.ex_EX_control <= CTRL_BUBBLE.ex;
                bus.ex_M_control  <= CTRL_BUBBLE.m;
                bus.ex_WB_control <= CTRL_BUBBLE.wb;
            end else begin
                bus.ex_EX_control <= bus.id_EX_control;
                bus.ex_M_control  <= bus.id_M_control;
                bus.ex_WB_control <= bus.id_WB_control;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: driver queues expected register contents, monitor checks them after each edge.
module tb_id_ex_stage;

    localparam int TB_CNT_W = 4;

    localparam logic [3:0] R_EX  = 4'b1010;
    localparam logic [3:0] R_M   = 4'b0000;
    localparam logic [1:0] R_WB  = 2'b11;
    localparam logic [3:0] LW_EX = 4'b0100;
    localparam logic [3:0] LW_M  = 4'b1000;
    localparam logic [1:0] LW_WB = 2'b10;
    localparam logic [3:0] SW_EX = 4'b0100;
    localparam logic [3:0] SW_M  = 4'b0100;
    localparam logic [1:0] SW_WB = 2'b00;

    typedef struct packed {
        logic [3:0]  ex;
        logic [3:0]  m;
        logic [1:0]  wb;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } vec_t;

    typedef struct packed {
        logic [9:0]          ctrl;
        logic [9:0]          mask;
        logic [127:0]        data;
        logic [14:0]         addr;
        logic [TB_CNT_W-1:0] scnt;
        logic [TB_CNT_W-1:0] fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic cnt_clr = 1'b0;
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] flush_cnt;

    int errors = 0;
    int checks = 0;
    exp_t q[$];

    id_ex_if bus();

    id_ex_stage #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] ex, input logic [3:0] m, input logic [1:0] wb,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] imm);
        vec_t v;
        v.ex = ex; v.m = m; v.wb = wb;
        v.pc  = 32'h0000_1000 + {17'd0, rs, rt, rd};
        v.rsd = 32'hA000_0000 | {27'd0, rs};
        v.rtd = 32'hB000_0000 | {27'd0, rt};
        v.imm = imm;
        v.rs = rs; v.rt = rt; v.rd = rd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.id_EX_control = v.ex;
        bus.id_M_control  = v.m;
        bus.id_WB_control = v.wb;
        bus.id_pc_plus4   = v.pc;
        bus.id_rs_data    = v.rsd;
        bus.id_rt_data    = v.rtd;
        bus.id_imm        = v.imm;
        bus.id_rs         = v.rs;
        bus.id_rt         = v.rt;
        bus.id_rd         = v.rd;
    endtask

    // bub: expect the all-zero bubble; sc/fc: counters after the edge; st: stall before the edge.
    task automatic step(input vec_t v, input bit fl, input bit clr, input bit bub,
                        input int sc, input int fc, input bit st);
        exp_t e;
        @(negedge clk);
        drive(v);
        flush   = fl;
        cnt_clr = clr;
        #1;
        chk("stall_pre_edge", 128'(bus.stall), 128'(st));
        e.ctrl = bub ? 10'b0 : {v.ex, v.m, v.wb};
        e.mask = 10'h3FF;
        e.data = {v.pc, v.rsd, v.rtd, v.imm};
        e.addr = {v.rs, v.rt, v.rd};
        e.scnt = TB_CNT_W'(sc);
        e.fcnt = TB_CNT_W'(fc);
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ex_ctrl", 128'({bus.ex_EX_control, bus.ex_M_control, bus.ex_WB_control} & e.mask),
                    128'(e.ctrl & e.mask));
                chk("ex_data", {bus.ex_pc_plus4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm}, e.data);
                chk("ex_addr", 128'({bus.ex_rs, bus.ex_rt, bus.ex_rd}), 128'(e.addr));
                chk("counters", 128'({stall_cnt, flush_cnt}), 128'({e.scnt, e.fcnt}));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        vec_t r_t, lw8, dep8, lw0, sw7, lw6, dep6, r6;
        r_t  = mk(R_EX, R_M, R_WB, 5'd3, 5'd4, 5'd5, 32'hFFFF_FFF0);
        lw8  = mk(LW_EX, LW_M, LW_WB, 5'd2, 5'd8, 5'd0, 32'h0000_0010);
        dep8 = mk(R_EX, R_M, R_WB, 5'd8, 5'd9, 5'd10, 32'h0000_0000);
        lw0  = mk(LW_EX, LW_M, LW_WB, 5'd1, 5'd0, 5'd0, 32'h0000_0004);
        sw7  = mk(SW_EX, SW_M, SW_WB, 5'd0, 5'd7, 5'd0, 32'h0000_0008);
        lw6  = mk(LW_EX, LW_M, LW_WB, 5'd7, 5'd6, 5'd0, 32'h0000_000C);
        dep6 = mk(R_EX, R_M, R_WB, 5'd1, 5'd6, 5'd11, 32'h0000_0000);
        r6   = mk(R_EX, R_M, R_WB, 5'd6, 5'd2, 5'd12, 32'h0000_0000);

        drive(lw8);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ctrl", 128'({bus.ex_EX_control, bus.ex_M_control, bus.ex_WB_control}), 128'(0));
        chk("reset_data", {bus.ex_pc_plus4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm}, 128'(0));
        chk("reset_addr", 128'({bus.ex_rs, bus.ex_rt, bus.ex_rd}), 128'(0));
        chk("reset_cnt", 128'({stall_cnt, flush_cnt}), 128'(0));
        chk("reset_stall", 128'(bus.stall), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        step(r_t,  0, 0, 0, 0, 0, 0);
        step(lw8,  0, 0, 0, 0, 0, 0);
        step(dep8, 0, 0, 1, 1, 0, 1);
        step(dep8, 0, 0, 0, 1, 0, 0);
        step(lw0,  0, 0, 0, 1, 0, 0);
        step(sw7,  0, 0, 0, 1, 0, 0);
        step(lw6,  0, 0, 0, 1, 0, 0);
        step(dep6, 1, 0, 1, 1, 1, 0);
        step(r6,   0, 0, 0, 1, 1, 0);

        step(r_t,  0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            step(lw8,  0, 0, 0, (k - 1 > 15) ? 15 : k - 1, 0, 0);
            step(dep8, 0, 0, 1, (k > 15) ? 15 : k, 0, 1);
        end
        step(lw8,  0, 0, 0, 15, 0, 0);
        step(dep8, 0, 1, 1, 0, 0, 1);

        for (int i = 1; i <= 16; i++) begin
            step(r_t, 1, 0, 1, 0, (i > 15) ? 15 : i, 0);
        end
        step(lw8, 0, 0, 0, 0, 15, 0);

        @(negedge clk);
        drive(dep8);
        #1;
        chk("stall_before_reset", 128'(bus.stall), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("midstall_reset_ctrl", 128'({bus.ex_EX_control, bus.ex_M_control, bus.ex_WB_control}), 128'(0));
        chk("midstall_reset_addr", 128'({bus.ex_rs, bus.ex_rt, bus.ex_rd}), 128'(0));
        chk("midstall_reset_cnt", 128'({stall_cnt, flush_cnt}), 128'(0));
        chk("midstall_reset_stall", 128'(bus.stall), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 128'(q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
